// File: rtl/intra4x4_pkg.sv
// Shared types and tables for the intra 4x4 macroblock scheduler:
// FSM states, z-scan block geometry and the internal top-right availability mask.
package intra4x4_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DEC,
    WAIT_RECON,
    DONE
  } state_t;

  // Entry n holds {y[1:0], x[1:0]} of z-scan block n.
  localparam logic [15:0][3:0] ZSCAN_YX = {
    4'd15, 4'd14, 4'd11, 4'd10, 4'd13, 4'd12, 4'd9, 4'd8,
    4'd7,  4'd6,  4'd3,  4'd2,  4'd5,  4'd4,  4'd1, 4'd0
  };

  // Blocks whose top-right neighbour lies inside the MB and is already decoded.
  localparam logic [15:0] TOPRIGHT_INTERNAL = 16'h5744;

  function automatic logic [3:0] xy_to_idx(input logic [1:0] x, input logic [1:0] y);
    return {y[1], x[1], y[0], x[0]};
  endfunction

endpackage

// File: rtl/intra4x4_nbr_avail.sv
// Combinational neighbour-availability decode for one 4x4 block, from its
// z-scan index and the latched macroblock-level availability flags.
module intra4x4_nbr_avail
  import intra4x4_pkg::*;
(
  input  logic [3:0] blk_idx,
  input  logic       mb_top,
  input  logic       mb_left,
  input  logic       mb_topright,
  output logic [1:0] blk_x,
  output logic [1:0] blk_y,
  output logic       top_avail,
  output logic       left_avail,
  output logic       topright_avail
);

  always_comb begin
    blk_x      = ZSCAN_YX[blk_idx][1:0];
    blk_y      = ZSCAN_YX[blk_idx][3:2];
    top_avail  = (blk_y != 2'd0) | mb_top;
    left_avail = (blk_x != 2'd0) | mb_left;
    case (blk_idx)
      4'd0, 4'd1, 4'd4: topright_avail = mb_top;
      4'd5:             topright_avail = mb_topright;
      default:          topright_avail = TOPRIGHT_INTERNAL[blk_idx];
    endcase
  end

endmodule

// File: rtl/intra4x4_mb_sched.sv
// Sequences the 16 luma 4x4 blocks of a macroblock through decision and reconstruction.
// Optional MPM / remainder outputs are built when INTRA4X4_MPM_EN is defined.
module intra4x4_mb_sched #(
  parameter int MODE_W      = intra4x4_pkg::MODE_W,
  parameter int MPM_DEFAULT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mb_top_avail,
  input  logic                  mb_left_avail,
  input  logic                  mb_topright_avail,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            blk_idx,
  output logic [1:0]            blk_x,
  output logic [1:0]            blk_y,
  output logic                  top_avail,
  output logic                  left_avail,
  output logic                  topright_avail,
  output logic                  dec_enable,
  input  logic                  dec_valid,
  input  logic [MODE_W-1:0]     dec_mode,
  input  logic                  recon_done,
  output logic [16*MODE_W-1:0]  mb_modes
`ifdef INTRA4X4_MPM_EN
  ,
  output logic [MODE_W-1:0]     mpm_mode,
  output logic                  prev_mode_flag,
  output logic [MODE_W-1:0]     rem_mode
`endif
);
  import intra4x4_pkg::*;

  state_t              state_reg;
  logic                busy_reg, done_reg, dec_enable_reg;
  logic [3:0]          idx_reg, idx_next;
  logic                mb_top_reg, mb_left_reg, mb_tr_reg;
  logic                mb_top_next, mb_left_next, mb_tr_next;
  logic [1:0]          blk_x_reg, blk_y_reg, x_next, y_next;
  logic                top_reg, left_reg, tr_reg, top_next, left_next, tr_next;
  logic [16*MODE_W-1:0] mb_modes_reg;
  logic                accept, advance;

  assign accept  = (state_reg == IDLE) && start;
  assign advance = (state_reg == WAIT_RECON) && recon_done && (idx_reg != 4'd15);

  // Descriptors are decoded from the upcoming index so they register in step with it.
  always_comb begin
    idx_next     = idx_reg;
    mb_top_next  = mb_top_reg;
    mb_left_next = mb_left_reg;
    mb_tr_next   = mb_tr_reg;
    if (accept) begin
      idx_next     = 4'd0;
      mb_top_next  = mb_top_avail;
      mb_left_next = mb_left_avail;
      mb_tr_next   = mb_topright_avail;
    end else if (advance) begin
      idx_next = idx_reg + 4'd1;
    end
  end

  intra4x4_nbr_avail u_nbr_avail (
    .blk_idx        (idx_next),
    .mb_top         (mb_top_next),
    .mb_left        (mb_left_next),
    .mb_topright    (mb_tr_next),
    .blk_x          (x_next),
    .blk_y          (y_next),
    .top_avail      (top_next),
    .left_avail     (left_next),
    .topright_avail (tr_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      dec_enable_reg <= 1'b0;
      idx_reg        <= 4'd0;
      mb_top_reg     <= 1'b0;
      mb_left_reg    <= 1'b0;
      mb_tr_reg      <= 1'b0;
      blk_x_reg      <= 2'd0;
      blk_y_reg      <= 2'd0;
      top_reg        <= 1'b0;
      left_reg       <= 1'b0;
      tr_reg         <= 1'b0;
      mb_modes_reg   <= '0;
    end else begin
      idx_reg        <= idx_next;
      mb_top_reg     <= mb_top_next;
      mb_left_reg    <= mb_left_next;
      mb_tr_reg      <= mb_tr_next;
      blk_x_reg      <= x_next;
      blk_y_reg      <= y_next;
      top_reg        <= top_next;
      left_reg       <= left_next;
      tr_reg         <= tr_next;
      dec_enable_reg <= 1'b0;
      done_reg       <= 1'b0;
      case (state_reg)
        IDLE: if (start) begin
          busy_reg       <= 1'b1;
          mb_modes_reg   <= '0;
          dec_enable_reg <= 1'b1;
          state_reg      <= ISSUE;
        end
        ISSUE: state_reg <= WAIT_DEC;
        WAIT_DEC: if (dec_valid) begin
          mb_modes_reg[idx_reg*MODE_W +: MODE_W] <= dec_mode;
          state_reg <= WAIT_RECON;
        end
        WAIT_RECON: if (recon_done) begin
          if (idx_reg == 4'd15) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            dec_enable_reg <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy           = busy_reg;
  assign done           = done_reg;
  assign dec_enable     = dec_enable_reg;
  assign blk_idx        = idx_reg;
  assign blk_x          = blk_x_reg;
  assign blk_y          = blk_y_reg;
  assign top_avail      = top_reg;
  assign left_avail     = left_reg;
  assign topright_avail = tr_reg;
  assign mb_modes       = mb_modes_reg;

`ifdef INTRA4X4_MPM_EN
  logic [MODE_W-1:0] mode_a, mode_b, mpm_next, mpm_reg, rem_next, rem_reg;
  logic              flag_next, flag_reg;

  // Neighbours outside the MB have no stored mode and fall back to the default.
  always_comb begin
    mode_a = MODE_W'(MPM_DEFAULT);
    mode_b = MODE_W'(MPM_DEFAULT);
    if (blk_x_reg != 2'd0)
      mode_a = mb_modes_reg[xy_to_idx(blk_x_reg - 2'd1, blk_y_reg)*MODE_W +: MODE_W];
    if (blk_y_reg != 2'd0)
      mode_b = mb_modes_reg[xy_to_idx(blk_x_reg, blk_y_reg - 2'd1)*MODE_W +: MODE_W];
    mpm_next  = (mode_a < mode_b) ? mode_a : mode_b;
    flag_next = (dec_mode == mpm_reg);
    rem_next  = '0;
    if (!flag_next)
      rem_next = (dec_mode > mpm_reg) ? dec_mode - MODE_W'(1) : dec_mode;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mpm_reg  <= '0;
      flag_reg <= 1'b0;
      rem_reg  <= '0;
    end else begin
      mpm_reg <= mpm_next;
      if (state_reg == WAIT_DEC && dec_valid) begin
        flag_reg <= flag_next;
        rem_reg  <= rem_next;
      end
    end
  end

  assign mpm_mode       = mpm_reg;
  assign prev_mode_flag = flag_reg;
  assign rem_mode       = rem_reg;
`endif

endmodule

// File: tb/tb_intra4x4_mb_sched.sv
// Directed, table-driven bench for intra4x4_mb_sched (MPM checks when INTRA4X4_MPM_EN is defined).
module tb_intra4x4_mb_sched;

  logic        clk = 1'b0;
  logic        reset, start, mb_top_avail, mb_left_avail, mb_topright_avail;
  logic        busy, done, top_avail, left_avail, topright_avail, dec_enable;
  logic [3:0]  blk_idx;
  logic [1:0]  blk_x, blk_y;
  logic        dec_valid, recon_done;
  logic [2:0]  dec_mode;
  logic [47:0] mb_modes;
`ifdef INTRA4X4_MPM_EN
  logic [2:0]  mpm_mode, rem_mode;
  logic        prev_mode_flag;
`endif

  intra4x4_mb_sched dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .mb_top_avail      (mb_top_avail),
    .mb_left_avail     (mb_left_avail),
    .mb_topright_avail (mb_topright_avail),
    .busy              (busy),
    .done              (done),
    .blk_idx           (blk_idx),
    .blk_x             (blk_x),
    .blk_y             (blk_y),
    .top_avail         (top_avail),
    .left_avail        (left_avail),
    .topright_avail    (topright_avail),
    .dec_enable        (dec_enable),
    .dec_valid         (dec_valid),
    .dec_mode          (dec_mode),
    .recon_done        (recon_done),
    .mb_modes          (mb_modes)
`ifdef INTRA4X4_MPM_EN
    ,
    .mpm_mode          (mpm_mode),
    .prev_mode_flag    (prev_mode_flag),
    .rem_mode          (rem_mode)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] mode;
    logic [3:0] idx;
    logic [1:0] x;
    logic [1:0] y;
    logic [2:0] avl1;   // {top,left,topright} with all MB neighbours present
    logic [2:0] avl0;   // {top,left,topright} with no MB neighbours
    logic       chk;
    logic [2:0] mpm;
    logic       flag;
    logic [2:0] rem;
  } vec_t;

  vec_t vec [16];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, dec_cnt = 0, done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (dec_enable) dec_cnt <= dec_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic serve_block(input logic [2:0] mode, input bit spur, input bit poke, input int b,
                             input bit chk_mpm);
    @(negedge clk);
    check("dec_enable_one_cycle", dec_enable, 1'b0);
    if (spur) begin
      recon_done = 1'b1;
      @(negedge clk);
      recon_done = 1'b0;
      check("recon_in_wait_dec_ignored", {dec_enable, blk_idx}, {1'b0, 4'(b)});
    end
    if (poke) start = 1'b1;
    dec_valid = 1'b1;
    dec_mode  = mode;
    if (spur) recon_done = 1'b1;
    @(negedge clk);
    dec_valid  = 1'b0;
    recon_done = 1'b0;
    start      = 1'b0;
`ifdef INTRA4X4_MPM_EN
    if (chk_mpm) begin
      check("mpm_mode", mpm_mode, vec[b].mpm);
      check("prev_mode_flag", prev_mode_flag, vec[b].flag);
      check("rem_mode", rem_mode, vec[b].rem);
    end
`endif
    if (spur) begin
      dec_valid = 1'b1;
      dec_mode  = ~mode;
      @(negedge clk);
      dec_valid = 1'b0;
      check("recon_with_valid_dropped", {dec_enable, blk_idx}, {1'b0, 4'(b)});
    end
    recon_done = 1'b1;
    @(negedge clk);
    recon_done = 1'b0;
  endtask

  task automatic run_mb(input bit t, input bit l, input bit r, input logic [2:0] salt,
                        input bit corner, input bit spur, input int abort_at);
    logic [47:0] exp_modes;
    int          t0, d0, dn0;
    bit          ok;
    exp_modes = '0;
    d0 = dec_cnt;
    mb_top_avail = t; mb_left_avail = l; mb_topright_avail = r;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    for (int b = 0; b < 16; b++) begin
      ok = 1'b0;
      for (int w = 0; w < 8; w++) begin
        if (dec_enable) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      check("issue_seen", ok, 1'b1);
      if (!ok) return;
      check("blk_idx", blk_idx, vec[b].idx);
      check("blk_xy", {blk_x, blk_y}, {vec[b].x, vec[b].y});
      check("avail_tlr", {top_avail, left_avail, topright_avail}, corner ? vec[b].avl0 : vec[b].avl1);
      $display("blk %0d idx=%0d x=%0d y=%0d avail=%b%b%b", b, blk_idx, blk_x, blk_y,
               top_avail, left_avail, topright_avail);
      if (b == abort_at) begin
        dn0 = done_cnt;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_state", {busy, dec_enable, blk_idx}, 6'd0);
        check("abort_mb_modes", mb_modes, 48'd0);
        repeat (8) @(negedge clk);
        check("abort_no_done", done_cnt - dn0, 0);
        return;
      end
      serve_block(vec[b].mode ^ salt, spur && b == 5, spur && b == 7, b, vec[b].chk && salt == 3'd0);
      exp_modes[b*3 +: 3] = vec[b].mode ^ salt;
    end
    ok = 1'b0;
    for (int w = 0; w < 8; w++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("done_seen", ok, 1'b1);
    if (!spur) check("start_to_done_cycles", cyc - t0, 49);
    check("mb_modes", mb_modes, exp_modes);
    check("busy_low_at_done", busy, 1'b0);
    check("dec_enable_pulses", dec_cnt - d0, 16);
    $display("mb done: modes=%h cycles=%0d", mb_modes, cyc - t0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("mb_modes_stable", mb_modes, exp_modes);
  endtask

  initial begin
    //             mode  idx    x     y     avl1    avl0    chk   mpm   flg   rem
    vec[0]  = '{3'd5, 4'd0,  2'd0, 2'd0, 3'b111, 3'b000, 1'b1, 3'd0, 1'b0, 3'd4};
    vec[1]  = '{3'd6, 4'd1,  2'd1, 2'd0, 3'b111, 3'b010, 1'b1, 3'd0, 1'b0, 3'd5};
    vec[2]  = '{3'd4, 4'd2,  2'd0, 2'd1, 3'b111, 3'b101, 1'b1, 3'd0, 1'b0, 3'd3};
    vec[3]  = '{3'd4, 4'd3,  2'd1, 2'd1, 3'b110, 3'b110, 1'b1, 3'd4, 1'b1, 3'd0};
    vec[4]  = '{3'd0, 4'd4,  2'd2, 2'd0, 3'b111, 3'b010, 1'b0, 3'd0, 1'b0, 3'd0};
    vec[5]  = '{3'd1, 4'd5,  2'd3, 2'd0, 3'b111, 3'b010, 1'b0, 3'd0, 1'b0, 3'd0};
    vec[6]  = '{3'd7, 4'd6,  2'd2, 2'd1, 3'b111, 3'b111, 1'b0, 3'd0, 1'b0, 3'd0};
    vec[7]  = '{3'd3, 4'd7,  2'd3, 2'd1, 3'b110, 3'b110, 1'b0, 3'd0, 1'b0, 3'd0};
    vec[8]  = '{3'd2, 4'd8,  2'd0, 2'd2, 3'b111, 3'b101, 1'b0, 3'd0, 1'b0, 3'd0};
    vec[9]  = '{3'd5, 4'd9,  2'd1, 2'd2, 3'b111, 3'b111, 1'b0, 3'd0, 1'b0, 3'd0};
    vec[10] = '{3'd6, 4'd10, 2'd0, 2'd3, 3'b111, 3'b101, 1'b0, 3'd0, 1'b0, 3'd0};
    vec[11] = '{3'd1, 4'd11, 2'd1, 2'd3, 3'b110, 3'b110, 1'b0, 3'd0, 1'b0, 3'd0};
    vec[12] = '{3'd0, 4'd12, 2'd2, 2'd2, 3'b111, 3'b111, 1'b0, 3'd0, 1'b0, 3'd0};
    vec[13] = '{3'd7, 4'd13, 2'd3, 2'd2, 3'b110, 3'b110, 1'b0, 3'd0, 1'b0, 3'd0};
    vec[14] = '{3'd3, 4'd14, 2'd2, 2'd3, 3'b111, 3'b111, 1'b0, 3'd0, 1'b0, 3'd0};
    vec[15] = '{3'd2, 4'd15, 2'd3, 2'd3, 3'b110, 3'b110, 1'b0, 3'd0, 1'b0, 3'd0};

    reset = 1'b0; start = 1'b1; dec_valid = 1'b0; recon_done = 1'b0; dec_mode = 3'd0;
    mb_top_avail = 1'b1; mb_left_avail = 1'b1; mb_topright_avail = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_ctrl", {busy, done, dec_enable}, 3'b000);
      check("reset_desc", {blk_idx, blk_x, blk_y, top_avail, left_avail, topright_avail}, 11'd0);
      check("reset_mb_modes", mb_modes, 48'd0);
`ifdef INTRA4X4_MPM_EN
      check("reset_mpm", {mpm_mode, prev_mode_flag, rem_mode}, 7'd0);
`endif
    end
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, dec_enable}, 2'b00);

    run_mb(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, -1);  // zero-wait, all neighbours
    run_mb(1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b1, -1);  // corner MB with spurious inputs
    run_mb(1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 9);   // reset abort at block 9
    run_mb(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, -1);  // clean restart

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
